// File: rtl/forward_hazard_unit.sv
// Operand-forwarding select and load-use stall/bubble control beside the ID/EX register.
// Optional cumulative stall counter is built only when FWD_STALL_COUNT_EN is defined.
module forward_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            ForwardA_signal,
  output logic [1:0]            ForwardB_signal,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_count
);

  typedef enum logic {RUN, STALL} state_t;

  state_t stateQ, stateD;

  // ID/EX shadow (_p0), EX/MEM shadow (_p1), MEM/WB shadow (_p2)
  logic                  vld_p0, regWrite_p0, memRead_p0, usesRs_p0, usesRt_p0;
  logic [REG_ADDR_W-1:0] rd_p0, rs_p0, rt_p0;
  logic                  vld_p1, regWrite_p1;
  logic [REG_ADDR_W-1:0] rd_p1;
  logic                  vld_p2, regWrite_p2;
  logic [REG_ADDR_W-1:0] rd_p2;

  logic hz;
  logic squash;

  // EX/MEM beats MEM/WB; register 0 and unused sources never forward.
  function automatic logic [1:0] fwdSel(
    input logic                  srcUsed,
    input logic [REG_ADDR_W-1:0] src,
    input logic                  memVld,
    input logic                  memWr,
    input logic [REG_ADDR_W-1:0] memRd,
    input logic                  wbVld,
    input logic                  wbWr,
    input logic [REG_ADDR_W-1:0] wbRd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (srcUsed) begin
      if (memVld && memWr && (memRd != '0) && (memRd == src))
        sel = 2'b10;
      else if (wbVld && wbWr && (wbRd != '0) && (wbRd == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  assign ForwardA_signal = fwdSel(usesRs_p0, rs_p0, vld_p1, regWrite_p1, rd_p1,
                                  vld_p2, regWrite_p2, rd_p2);
  assign ForwardB_signal = fwdSel(usesRt_p0, rt_p0, vld_p1, regWrite_p1, rd_p1,
                                  vld_p2, regWrite_p2, rd_p2);

  assign hz = id_valid && !flush && vld_p0 && memRead_p0 && (rd_p0 != '0) &&
              ((id_uses_rs && (id_rs == rd_p0)) || (id_uses_rt && (id_rt == rd_p0)));

  always_comb begin
    stateD = stateQ;
    stall  = 1'b0;
    bubble = 1'b0;
    case (stateQ)
      RUN: begin
        if (hz) begin
          stall  = 1'b1;
          bubble = 1'b1;
          stateD = STALL;
        end
      end
      STALL: stateD = RUN;
      default: stateD = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) stateQ <= RUN;
    else       stateQ <= stateD;
  end

  assign squash = bubble || flush || !id_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0      <= 1'b0;
      regWrite_p0 <= 1'b0;
      memRead_p0  <= 1'b0;
      usesRs_p0   <= 1'b0;
      usesRt_p0   <= 1'b0;
      rd_p0       <= '0;
      rs_p0       <= '0;
      rt_p0       <= '0;
      vld_p1      <= 1'b0;
      regWrite_p1 <= 1'b0;
      rd_p1       <= '0;
      vld_p2      <= 1'b0;
      regWrite_p2 <= 1'b0;
      rd_p2       <= '0;
    end else begin
      vld_p2      <= vld_p1;
      regWrite_p2 <= regWrite_p1;
      rd_p2       <= rd_p1;
      vld_p1      <= vld_p0;
      regWrite_p1 <= regWrite_p0;
      rd_p1       <= rd_p0;
      if (squash) begin
        vld_p0      <= 1'b0;
        regWrite_p0 <= 1'b0;
        memRead_p0  <= 1'b0;
        usesRs_p0   <= 1'b0;
        usesRt_p0   <= 1'b0;
        rd_p0       <= '0;
        rs_p0       <= '0;
        rt_p0       <= '0;
      end else begin
        vld_p0      <= 1'b1;
        regWrite_p0 <= id_reg_write;
        memRead_p0  <= id_mem_read;
        usesRs_p0   <= id_uses_rs;
        usesRt_p0   <= id_uses_rt;
        rd_p0       <= id_rd;
        rs_p0       <= id_rs;
        rt_p0       <= id_rt;
      end
    end
  end

`ifdef FWD_STALL_COUNT_EN
  logic [CNT_W-1:0] stallCnt;

  // Saturates rather than wrapping so a long run never reports a small count.
  always_ff @(posedge clk) begin
    if (reset)
      stallCnt <= '0;
    else if (stall && (stallCnt != '1))
      stallCnt <= stallCnt + 1'b1;
  end

  assign stall_count = stallCnt;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Randomized bench: an instruction-history model predicts forward selects, stall/bubble and stall_count.
module tb_forward_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        idValid, idUsesRs, idUsesRt, idRegWrite, idMemRead, flush;
  logic [4:0]  idRs, idRt, idRd;
  logic [1:0]  fwdA, fwdB;
  logic        stall, bubble;
  logic [31:0] stallCount;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  forward_hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk),
    .reset(reset),
    .id_valid(idValid),
    .id_rs(idRs),
    .id_rt(idRt),
    .id_uses_rs(idUsesRs),
    .id_uses_rt(idUsesRt),
    .id_rd(idRd),
    .id_reg_write(idRegWrite),
    .id_mem_read(idMemRead),
    .flush(flush),
    .ForwardA_signal(fwdA),
    .ForwardB_signal(fwdB),
    .stall(stall),
    .bubble(bubble),
    .stall_count(stallCount)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ur;
    logic       ut;
    logic       mr;
  } instr_t;

  // hist[0] is the instruction now in EX, hist[1] the one before it, hist[2] the one before that.
  instr_t      hist[$];
  logic        prevStall;
  logic [31:0] cnt;

  function automatic logic [1:0] expFwd(input logic used, input logic [4:0] src);
    if (!used) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (hist[k].v && hist[k].rw && hist[k].rd != 0 && hist[k].rd == src)
        return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  task automatic modelReset();
    hist.delete();
    for (int k = 0; k < 3; k++) hist.push_back(instr_t'('0));
    prevStall = 1'b0;
    cnt       = 32'd0;
  endtask

  function automatic logic [31:0] expCount();
`ifdef FWD_STALL_COUNT_EN
    return cnt;
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    logic   hz, expStall;
    instr_t ni;

    reset = 1'b1; idValid = 1'b0; idUsesRs = 1'b0; idUsesRt = 1'b0; idRegWrite = 1'b0;
    idMemRead = 1'b0; flush = 1'b0; idRs = '0; idRt = '0; idRd = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVal("rst_fwdA", {30'd0, fwdA}, 32'd0);
    checkVal("rst_fwdB", {30'd0, fwdB}, 32'd0);
    checkVal("rst_stall", {31'd0, stall}, 32'd0);
    checkVal("rst_bubble", {31'd0, bubble}, 32'd0);
    checkVal("rst_count", stallCount, 32'd0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 99) < 2);
      idValid    = ($urandom_range(0, 99) < 85);
      flush      = ($urandom_range(0, 99) < 10);
      idRs       = 5'($urandom_range(0, 3));
      idRt       = 5'($urandom_range(0, 3));
      idRd       = 5'($urandom_range(0, 3));
      idUsesRs   = ($urandom_range(0, 99) < 75);
      idUsesRt   = ($urandom_range(0, 99) < 60);
      idRegWrite = ($urandom_range(0, 99) < 80);
      idMemRead  = ($urandom_range(0, 99) < 35);
      #1;
      hz = idValid && !flush && hist[0].v && hist[0].mr && hist[0].rd != 0 &&
           ((idUsesRs && idRs == hist[0].rd) || (idUsesRt && idRt == hist[0].rd));
      expStall = hz && !prevStall;
      checkVal("fwdA", {30'd0, fwdA}, {30'd0, expFwd(hist[0].ur, hist[0].rs)});
      checkVal("fwdB", {30'd0, fwdB}, {30'd0, expFwd(hist[0].ut, hist[0].rt)});
      checkVal("stall", {31'd0, stall}, {31'd0, expStall});
      checkVal("bubble", {31'd0, bubble}, {31'd0, expStall});
      checkVal("count", stallCount, expCount());
      @(posedge clk);
      if (reset) begin
        modelReset();
      end else begin
        ni = '0;
        if (!(expStall || flush || !idValid)) begin
          ni.v  = 1'b1;  ni.rd = idRd;     ni.rw = idRegWrite;
          ni.rs = idRs;  ni.rt = idRt;     ni.ur = idUsesRs;
          ni.ut = idUsesRt; ni.mr = idMemRead;
        end
        hist.push_front(ni);
        void'(hist.pop_back());
        if (expStall && cnt != 32'hFFFF_FFFF) cnt = cnt + 1;
        prevStall = expStall;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
